pc_fetch_ctrl: RTL and testbench

- Consumer and controller of the 4-bit program counter's `load`/`data`/`out` interface. It reads `out` as `pc_in`, fetches the instruction at that address from an internal 16-entry program store, and issues it downstream over a valid/ready handshake.
- It drives `load`/`data` back into the PC to start at a vector, take jumps, hold on back-pressure, and halt.
- Sits between the PC and the execute/decode stage.

---
 rtl/pc_fetch_ctrl_if.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 118 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// PC / program-store / downstream-issue bus for pc_fetch_ctrl.
// master = fetch controller, slave = the PC, programmer and consumer side.
interface pc_fetch_ctrl_if #(
  parameter int AW = 4,
  parameter int IW = 8
);
  logic [AW-1:0] pc_in;
  logic          pc_load;
  logic [AW-1:0] pc_data;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_wdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_addr;
  logic          halted;

  modport master (
    input  pc_in, prog_we, prog_addr, prog_wdata, instr_ready,
    output pc_load, pc_data, instr_valid, instr, instr_addr, halted
  );
  modport slave (
    output pc_in, prog_we, prog_addr, prog_wdata, instr_ready,
    input  pc_load, pc_data, instr_valid, instr, instr_addr, halted
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: steers an external PC, reads a 2**AW-entry program store and issues
// instructions over valid/ready. Optional macro FETCH_JUMP_COUNT_EN adds a saturating JMP counter.
module pc_fetch_ctrl #(
  parameter int AW         = 4,
  parameter int IW         = 8,
  parameter int START_ADDR = 0
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_ctrl_if.master bus
`ifdef FETCH_JUMP_COUNT_EN
  ,
  output logic [7:0]      jump_count
`endif
);

  localparam logic [AW-1:0] START = AW'(START_ADDR);
  localparam logic [3:0]    OP_JMP  = 4'hF;
  localparam logic [3:0]    OP_HALT = 4'hE;

  typedef enum logic [1:0] {S_VEC, S_RUN, S_HALT} state_e;

  state_e        state_q, state_d;
  logic          vld_q, vld_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          halted_q, halted_d;
  logic          pc_load;
  logic [AW-1:0] pc_data;

  logic [IW-1:0] mem [2**AW];
  logic [IW-1:0] fetched;
  logic [3:0]    opcode;
  logic          slot_free;

  // Store is intentionally not reset; a same-cycle write is seen by the fetch one cycle later.
  always_ff @(posedge clk) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_wdata;
  end

  assign fetched   = mem[bus.pc_in];
  assign opcode    = fetched[IW-1 -: 4];
  assign slot_free = !vld_q || bus.instr_ready;

`ifdef FETCH_JUMP_COUNT_EN
  logic [7:0] jc_q, jc_d;
`endif

  always_comb begin
    state_d  = state_q;
    vld_d    = vld_q && !bus.instr_ready;
    instr_d  = instr_q;
    addr_d   = addr_q;
    halted_d = halted_q;
    pc_load  = 1'b1;
    pc_data  = bus.pc_in;
`ifdef FETCH_JUMP_COUNT_EN
    jc_d     = jc_q;
`endif
    case (state_q)
      S_VEC: begin
        pc_data = START;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (opcode == OP_JMP) begin
          pc_data = fetched[AW-1:0];
`ifdef FETCH_JUMP_COUNT_EN
          if (jc_q != 8'hFF) jc_d = jc_q + 8'd1;
`endif
        end else if (opcode == OP_HALT) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (slot_free) begin
          // Issue and let the PC increment; a stalled slot falls through to PC hold.
          vld_d   = 1'b1;
          instr_d = fetched;
          addr_d  = bus.pc_in;
          pc_load = 1'b0;
        end
      end
      S_HALT: halted_d = 1'b1;
      default: state_d = S_VEC;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_VEC;
      vld_q    <= 1'b0;
      instr_q  <= '0;
      addr_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
      halted_q <= halted_d;
    end
  end

`ifdef FETCH_JUMP_COUNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) jc_q <= '0;
    else      jc_q <= jc_d;
  end
  assign jump_count = jc_q;
`endif

  assign bus.pc_load     = pc_load;
  assign bus.pc_data     = pc_data;
  assign bus.instr_valid = vld_q;
  assign bus.instr       = instr_q;
  assign bus.instr_addr  = addr_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a behavioural 4-bit PC closing the loop.
module tb_pc_fetch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] pc_q = 4'h9;
  int checks = 0;
  int fails  = 0;
`ifdef FETCH_JUMP_COUNT_EN
  logic [7:0] jc;
`endif

  pc_fetch_ctrl_if #(.AW(4), .IW(8)) bus ();

  pc_fetch_ctrl #(.AW(4), .IW(8), .START_ADDR(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef FETCH_JUMP_COUNT_EN
    ,
    .jump_count (jc)
`endif
  );

  always #5 clk = ~clk;

  // PC model: load pc_data when pc_load, else increment mod 16.
  always @(posedge clk) pc_q <= bus.pc_load ? bus.pc_data : pc_q + 4'd1;
  assign bus.pc_in = pc_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_wdata = d;
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] i, input logic [3:0] a);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'(v));
    chk({tag, "_instr"}, 32'(bus.instr), 32'(i));
    chk({tag, "_addr"},  32'(bus.instr_addr), 32'(a));
  endtask

  task automatic chk_pc(input string tag, input logic l, input logic [3:0] d);
    chk({tag, "_pc_load"}, 32'(bus.pc_load), 32'(l));
    if (l) chk({tag, "_pc_data"}, 32'(bus.pc_data), 32'(d));
  endtask

  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0; bus.instr_ready = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk_out("reset", 1'b0, 8'h00, 4'h0);
    chk("reset_halted", 32'(bus.halted), 32'd0);
    chk_pc("reset", 1'b1, 4'h0);

    // Phase A: stream, jump loop, stall, async reset mid-stall
    wr(4'd0, 8'h11); wr(4'd1, 8'h22); wr(4'd2, 8'h33); wr(4'd3, 8'hF0);
    bus.instr_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk_pc("vec", 1'b1, 4'h0);
    chk("vec_valid", 32'(bus.instr_valid), 32'd0);
    tick(); chk_pc("run0", 1'b0, 4'h0); chk("run0_valid", 32'(bus.instr_valid), 32'd0);
    tick(); chk_out("iss0", 1'b1, 8'h11, 4'h0); chk_pc("iss0", 1'b0, 4'h0);
    tick(); chk_out("iss1", 1'b1, 8'h22, 4'h1); chk_pc("iss1", 1'b0, 4'h0);
    tick(); chk_out("iss2", 1'b1, 8'h33, 4'h2); chk_pc("jmp", 1'b1, 4'h0);
    tick(); chk("bubble_valid", 32'(bus.instr_valid), 32'd0); chk_pc("bubble", 1'b0, 4'h0);
`ifdef FETCH_JUMP_COUNT_EN
    chk("jc1", 32'(jc), 32'd1);
`endif
    tick(); chk_out("reiss0", 1'b1, 8'h11, 4'h0);
    bus.instr_ready = 1'b0;
    #1;
    chk_pc("stall0", 1'b1, 4'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out("stall", 1'b1, 8'h11, 4'h0);
      chk_pc("stall", 1'b1, 4'h1);
    end
    bus.instr_ready = 1'b1;
    tick(); chk_out("resume1", 1'b1, 8'h22, 4'h1);
    tick(); chk_out("resume2", 1'b1, 8'h33, 4'h2);
    tick(); chk("bubble2_valid", 32'(bus.instr_valid), 32'd0);
`ifdef FETCH_JUMP_COUNT_EN
    chk("jc2", 32'(jc), 32'd2);
`endif
    tick(); chk_out("loop2", 1'b1, 8'h11, 4'h0);
    bus.instr_ready = 1'b0;
    tick(); chk_out("stall_b", 1'b1, 8'h11, 4'h0);
    rst = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 8'h00, 4'h0);
    chk_pc("async_rst", 1'b1, 4'h0);
`ifdef FETCH_JUMP_COUNT_EN
    chk("jc_rst", 32'(jc), 32'd0);
`endif

    // Phase B: HALT with a pending instruction draining afterwards
    wr(4'd3, 8'h44); wr(4'd4, 8'h55); wr(4'd5, 8'hE0);
    bus.instr_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick(); chk_out("b0", 1'b1, 8'h11, 4'h0);
    tick(); chk_out("b1", 1'b1, 8'h22, 4'h1);
    tick(); chk_out("b2", 1'b1, 8'h33, 4'h2);
    tick(); chk_out("b3", 1'b1, 8'h44, 4'h3);
    tick(); chk_out("b4", 1'b1, 8'h55, 4'h4);
    bus.instr_ready = 1'b0;
    #1;
    chk_pc("halt_op", 1'b1, 4'h5);
    chk("halt_op_halted", 32'(bus.halted), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("halted", 32'(bus.halted), 32'd1);
      chk_out("halt_pend", 1'b1, 8'h55, 4'h4);
      chk_pc("halt_hold", 1'b1, 4'h5);
    end
    bus.instr_ready = 1'b1;
    tick();
    chk("drain_valid", 32'(bus.instr_valid), 32'd0);
    chk("drain_halted", 32'(bus.halted), 32'd1);
    chk_pc("drain", 1'b1, 4'h5);
    tick();
    chk("halt_idle_valid", 32'(bus.instr_valid), 32'd0);
    chk("halt_pc", 32'(pc_q), 32'd5);

    // Phase C: 16 plain instructions, PC wrap 15 -> 0
    rst = 1'b0;
    for (int k = 0; k < 16; k++) wr(4'(k), 8'h10 + 8'(k));
    rst = 1'b1;
    tick();
    for (int k = 0; k < 18; k++) begin
      tick();
      chk_out("wrap", 1'b1, 8'h10 + 8'(k % 16), 4'(k % 16));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
